// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames (8E1 when UART_RX_PARITY_EN is defined) from an asynchronous
// serial line, with a one-cycle rx_valid strobe per good byte and framing/parity error pulses.
module uart_rx #(
  parameter int BAUDRATE   = 115200,
  parameter int CLOCK_FREQ = 27000000
) (
  input  logic       clock,
  input  logic       n_reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       parity_err
);

  // BAUD_TICKS must be at least 4 so that both half-bit and full-bit counts are non-zero.
  localparam int          BAUD_TICKS = CLOCK_FREQ / BAUDRATE;
  localparam int          HALF_TICKS = BAUD_TICKS / 2;
  localparam logic [15:0] BAUD_LAST  = 16'(BAUD_TICKS - 1);
  localparam logic [15:0] HALF_LAST  = 16'(HALF_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  logic [1:0]  r_sync;
  logic        r_rx_prev;
  state_t      r_state,   w_state_next;
  logic [15:0] r_cnt,     w_cnt_next;
  logic [2:0]  r_idx,     w_idx_next;
  logic [7:0]  r_shift,   w_shift_next;
  logic [7:0]  r_data,    w_data_next;
  logic        r_valid,   w_valid_next;
  logic        r_busy;
  logic        r_ferr,    w_ferr_next;
`ifdef UART_RX_PARITY_EN
  logic        r_perr,    w_perr_next;
  logic        r_par_bad, w_par_bad_next;
`endif
  logic        w_rx_s;

  assign w_rx_s = r_sync[1];

  // NOTE: synchronizer resets to the idle level (1) so reset release never looks like a start bit.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], rx};
      r_rx_prev <= w_rx_s;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 16'd1;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_data_next  = r_data;
    w_valid_next = 1'b0;
    w_ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_perr_next    = 1'b0;
    w_par_bad_next = r_par_bad;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_next = 16'd0;
        // Only a genuine high-to-low transition starts a frame.
        if (r_rx_prev && !w_rx_s) begin
          w_state_next = S_START;
`ifdef UART_RX_PARITY_EN
          w_par_bad_next = 1'b0;
`endif
        end
      end
      S_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_next = 16'd0;
          w_idx_next = 3'd0;
          w_state_next = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == BAUD_LAST) begin
          w_cnt_next   = 16'd0;
          w_shift_next = {w_rx_s, r_shift[7:1]};
          w_idx_next   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_cnt == BAUD_LAST) begin
          w_cnt_next     = 16'd0;
          w_par_bad_next = w_rx_s ^ (^r_shift);
          w_state_next   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (r_cnt == BAUD_LAST) begin
          w_cnt_next = 16'd0;
          if (w_rx_s) begin
            w_state_next = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (r_par_bad) begin
              w_perr_next = 1'b1;
            end else begin
              w_data_next  = r_shift;
              w_valid_next = 1'b1;
            end
`else
            w_data_next  = r_shift;
            w_valid_next = 1'b1;
`endif
          end else begin
            w_ferr_next  = 1'b1;
            w_state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        w_cnt_next = 16'd0;
        if (w_rx_s) w_state_next = S_IDLE;
      end
      default: begin
        w_cnt_next   = 16'd0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_idx   <= 3'd0;
      r_shift <= 8'd0;
      r_data  <= 8'd0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_data  <= w_data_next;
      r_valid <= w_valid_next;
      r_busy  <= (w_state_next != S_IDLE);
      r_ferr  <= w_ferr_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_perr    <= 1'b0;
      r_par_bad <= 1'b0;
    end else begin
      r_perr    <= w_perr_next;
      r_par_bad <= w_par_bad_next;
    end
  end
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out  = r_data;
  assign rx_valid  = r_valid;
  assign rx_busy   = r_busy;
  assign frame_err = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit, expected pulses are queued as
// each frame is driven and popped by a monitor whenever the receiver emits a pulse.
module tb_uart_rx;

  localparam int BIT  = 234;
  localparam int HALF = 117;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int EXP_LAT = 2 + HALF + (FRAME_BITS - 1) * BIT;

  typedef struct packed {
    logic [1:0] kind;   // 1 = valid, 2 = frame error, 3 = parity error
    logic [7:0] data;
  } ev_t;

  logic       clock = 1'b0;
  logic       n_reset;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_valid, rx_busy, frame_err, parity_err;

  int  n_pass  = 0;
  int  n_total = 0;
  int  cyc     = 0;
  int  t_fall  = 0;
  int  t_valid = 0;
  int  t_prev  = 0;
  ev_t exp_q[$];
  ev_t mon_e;
  logic [1:0] mon_k;

  uart_rx #(.BAUDRATE(115200), .CLOCK_FREQ(27000000)) dut (
    .clock(clock), .n_reset(n_reset), .rx(rx), .data_out(data_out),
    .rx_valid(rx_valid), .rx_busy(rx_busy), .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input logic [1:0] kind, input logic [7:0] d);
    ev_t e;
    e.kind = kind;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // par_ok selects correct even parity (ignored in 8N1 builds); stop_len in bit times.
  task automatic send_frame(input logic [7:0] d, input logic par_ok,
                            input logic stop_bit, input int stop_len);
    rx = 1'b0;
    t_fall = cyc;
    wait_cycles(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cycles(BIT);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ ~par_ok;
    wait_cycles(BIT);
`endif
    rx = stop_bit;
    wait_cycles(stop_len * BIT);
    rx = 1'b1;
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  always @(negedge clock) begin
    if (rx_valid || frame_err || parity_err) begin
      mon_k = rx_valid ? 2'd1 : (frame_err ? 2'd2 : 2'd3);
      check("pulse_exclusive", 32'(rx_valid) + 32'(frame_err) + 32'(parity_err), 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, rx_valid, frame_err, parity_err}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind", 32'(mon_k), 32'(mon_e.kind));
        if (mon_k == 2'd1) check("event_data", 32'(data_out), 32'(mon_e.data));
      end
      if (rx_valid) begin
        t_prev  = t_valid;
        t_valid = cyc;
      end
    end
  end

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int lat;
    rx = 1'b1;
    n_reset = 1'b0;
    wait_cycles(3);
    check("rst_data_out",   32'(data_out),   32'h00);
    check("rst_rx_valid",   32'(rx_valid),   32'd0);
    check("rst_rx_busy",    32'(rx_busy),    32'd0);
    check("rst_frame_err",  32'(frame_err),  32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    n_reset = 1'b1;
    wait_cycles(2 * BIT);

    // Basic frame and its latency.
    push(2'd1, 8'h55);
    send_frame(8'h55, 1'b1, 1'b1, 1);
    lat = t_valid - t_fall;
    check("latency_55", 32'(lat >= EXP_LAT - 2 && lat <= EXP_LAT + 2), 32'd1);
    check("data_55", 32'(data_out), 32'h55);
    check("busy_low_after_55", 32'(rx_busy), 32'd0);
    wait_cycles(BIT);

    // Short glitch: busy briefly, no pulses, data held.
    busy_cnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i == 50) rx = 1'b1;
      wait_cycles(1);
      if (rx_busy) busy_cnt++;
    end
    check("glitch_busy_len", 32'(busy_cnt > 0 && busy_cnt <= 120), 32'd1);
    check("glitch_data_held", 32'(data_out), 32'h55);
    wait_cycles(BIT);

    // Framing error with held-low line, then recovery.
    push(2'd1, 8'hA3);
    send_frame(8'hA3, 1'b1, 1'b1, 1);
    wait_cycles(BIT);
    push(2'd2, 8'h00);
    send_frame(8'h3C, 1'b1, 1'b0, 3);
    wait_cycles(2 * BIT);
    check("ferr_data_held", 32'(data_out), 32'hA3);
    check("ferr_busy_low", 32'(rx_busy), 32'd0);
    push(2'd1, 8'h81);
    send_frame(8'h81, 1'b1, 1'b1, 1);
    check("data_81", 32'(data_out), 32'h81);
    wait_cycles(BIT);

    // Back-to-back frames with no idle gap.
    push(2'd1, 8'h00);
    push(2'd1, 8'hFF);
    send_frame(8'h00, 1'b1, 1'b1, 1);
    send_frame(8'hFF, 1'b1, 1'b1, 1);
    wait_cycles(BIT);
    check("b2b_spacing", 32'((t_valid - t_prev) >= FRAME_BITS * BIT - 2 &&
                             (t_valid - t_prev) <= FRAME_BITS * BIT + 2), 32'd1);
    check("b2b_data_ff", 32'(data_out), 32'hFF);

    // Reset during data bit 4 of a frame.
    rx = 1'b0;
    wait_cycles(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      wait_cycles(BIT);
    end
    rx = 1'b0;
    wait_cycles(HALF);
    n_reset = 1'b0;
    #1;
    check("midrst_data_out",  32'(data_out),  32'h00);
    check("midrst_rx_valid",  32'(rx_valid),  32'd0);
    check("midrst_rx_busy",   32'(rx_busy),   32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    wait_cycles(20);
    rx = 1'b1;
    wait_cycles(5);
    n_reset = 1'b1;
    wait_cycles(2 * BIT);
    push(2'd1, 8'h7E);
    send_frame(8'h7E, 1'b1, 1'b1, 1);
    check("data_7e", 32'(data_out), 32'h7E);
    wait_cycles(BIT);

`ifdef UART_RX_PARITY_EN
    push(2'd1, 8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1);
    check("par_good_data", 32'(data_out), 32'h07);
    wait_cycles(BIT);
    push(2'd1, 8'h5A);
    send_frame(8'h5A, 1'b1, 1'b1, 1);
    wait_cycles(BIT);
    push(2'd3, 8'h00);
    send_frame(8'h07, 1'b0, 1'b1, 1);
    check("par_bad_data_held", 32'(data_out), 32'h5A);
    wait_cycles(BIT);
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
